rca_arbiter: RTL and testbench

RCA_ARBITER -- requirements
Module: rca_arbiter

---
 rtl/rca_arbiter.sv | 131 +++++++++++++
 tb/tb_rca_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rca_arbiter.sv
// rca_arbiter: two-requester round-robin arbiter in front of a shared 4-bit ripple-carry adder, one slice per cycle
module rca_arbiter #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [4*NIB-1:0] a0,
    input  logic [4*NIB-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [4*NIB-1:0] a1,
    input  logic [4*NIB-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             valid,
    output logic [4*NIB-1:0] sum,
    output logic             cout,
    output logic             id
);
    localparam int W = 4 * NIB;
    localparam logic [2:0] LAST = 3'(NIB - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [2:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d, own_q, own_d, id_q, id_d, prio_q, prio_d;
    logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, valid_q, valid_d;
    logic take, pick, co;
    logic [3:0] sa, sb, ss;
    // prio_q names the requester that wins a tie; it always points away from the last one served
    always_comb begin
        take = (state_q == IDLE) && (req0 || req1);
        pick = (req0 && req1) ? prio_q : req1;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next state: a grant starts RUN, the last slice moves to DONE, DONE always returns to IDLE
    always_comb begin
        state_d = (state_q == IDLE) ? (take ? RUN : IDLE)
                : (state_q == RUN)  ? ((cnt_q == LAST) ? DONE : RUN)
                : IDLE;
    end
    // the one shared 4-bit ripple-carry adder: four chained full adders on the current slice
    always_comb begin
        logic cy;
        sa = a_q[{cnt_q, 2'b00} +: 4];
        sb = b_q[{cnt_q, 2'b00} +: 4];
        cy = carry_q;
        for (int i = 0; i < 4; i++) begin
            ss[i] = sa[i] ^ sb[i] ^ cy;
            cy    = (sa[i] & sb[i]) | (cy & (sa[i] ^ sb[i]));
        end
        co = cy;
    end
    // datapath next values: latch operands on grant, write one sum slice per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        own_d   = own_q;
        id_d    = id_q;
        prio_d  = prio_q;
        gnt0_d  = take && !pick;
        gnt1_d  = take && pick;
        valid_d = (state_q == RUN) && (cnt_q == LAST);
        if (take) begin
            a_d     = pick ? a1 : a0;
            b_d     = pick ? b1 : b0;
            carry_d = pick ? cin1 : cin0;
            cnt_d   = 3'd0;
            own_d   = pick;
            prio_d  = !pick;
        end
        if (state_q == RUN) begin
            sum_d[{cnt_q, 2'b00} +: 4] = ss;
            carry_d = co;
            cnt_d   = cnt_q + 3'd1;
            cout_d  = (cnt_q == LAST) ? co : cout_q;
            id_d    = (cnt_q == LAST) ? own_q : id_q;
        end
    end
    // datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= 3'd0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            own_q   <= 1'b0;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            own_q   <= own_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            valid_q <= valid_d;
        end
    end
    // outputs
    always_comb begin
        busy  = state_q != IDLE;
        gnt0  = gnt0_q;
        gnt1  = gnt1_q;
        valid = valid_q;
        sum   = sum_q;
        cout  = cout_q;
        id    = id_q;
    end
endmodule

// File: tb/tb_rca_arbiter.sv
// tb_rca_arbiter: scoreboard bench for rca_arbiter at NIB=4 and NIB=1
module tb_rca_arbiter;
    logic clk = 0, rst = 1;
    logic req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
    logic [15:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, sum;
    logic gnt0, gnt1, busy, valid, cout, id;
    logic r0 = 0, r1 = 0, c0 = 0, c1 = 0;
    logic [3:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0, s_n;
    logic g0_n, g1_n, busy_n, valid_n, cout_n, id_n;
    int checks = 0, failures = 0, cyc = 0, gcyc = 0, gcyc_n = 0;
    typedef struct packed {logic [15:0] s; logic c; logic id;} exp_t;
    typedef struct packed {logic [3:0] s; logic c; logic id;} exp1_t;
    exp_t q0[$];
    exp1_t q1[$];
    exp_t e0;
    exp1_t e1;

    rca_arbiter #(.NIB(4)) u0 (.clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1), .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .valid(valid), .sum(sum), .cout(cout), .id(id));
    rca_arbiter #(.NIB(1)) u1 (.clk(clk), .rst(rst), .req0(r0), .a0(x0), .b0(y0), .cin0(c0),
        .req1(r1), .a1(x1), .b1(y1), .cin1(c1), .gnt0(g0_n), .gnt1(g1_n), .busy(busy_n),
        .valid(valid_n), .sum(s_n), .cout(cout_n), .id(id_n));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // monitor for the NIB=4 instance
    always @(negedge clk) begin
        if (gnt0 || gnt1) begin
            gcyc = cyc;
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 0);
        end
        if (valid) begin
            if (q0.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e0 = q0.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, e0.s});
                chk("cout", {31'd0, cout}, {31'd0, e0.c});
                chk("id", {31'd0, id}, {31'd0, e0.id});
                chk("latency", cyc - gcyc, 4);
            end
        end
    end

    // monitor for the NIB=1 instance
    always @(negedge clk) begin
        if (g0_n || g1_n) begin
            gcyc_n = cyc;
            chk("gnt_exclusive_n1", {31'd0, g0_n & g1_n}, 0);
        end
        if (valid_n) begin
            if (q1.size() == 0) chk("unexpected_valid_n1", 1, 0);
            else begin
                e1 = q1.pop_front();
                chk("sum_n1", {28'd0, s_n}, {28'd0, e1.s});
                chk("cout_n1", {31'd0, cout_n}, {31'd0, e1.c});
                chk("id_n1", {31'd0, id_n}, {31'd0, e1.id});
                chk("latency_n1", cyc - gcyc_n, 1);
            end
        end
    end

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic n);
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b} + {16'd0, c};
        return '{s: r[15:0], c: r[16], id: n};
    endfunction

    task automatic wait_gnt(output logic who, output int at);
        who = 0;
        at = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                who = gnt1;
                at = cyc;
                return;
            end
        end
        chk("gnt_timeout", 0, 1);
    endtask

    task automatic issue(input logic n, input logic [15:0] a, input logic [15:0] b, input logic c);
        logic w;
        int t;
        if (n) begin a1 = a; b1 = b; cin1 = c; req1 = 1; end
        else   begin a0 = a; b0 = b; cin0 = c; req0 = 1; end
        q0.push_back(model(a, b, c, n));
        wait_gnt(w, t);
        chk("gnt_who", {31'd0, w}, {31'd0, n});
        req0 = 0;
        req1 = 0;
    endtask

    task automatic issue1(input logic n, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] r;
        int i;
        r = {1'b0, a} + {1'b0, b} + {4'd0, c};
        if (n) begin x1 = a; y1 = b; c1 = c; r1 = 1; end
        else   begin x0 = a; y0 = b; c0 = c; r0 = 1; end
        q1.push_back('{s: r[3:0], c: r[4], id: n});
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (g0_n || g1_n) break;
        end
        chk("gnt_who_n1", {31'd0, g1_n}, {31'd0, n});
        r0 = 0;
        r1 = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        chk("drained", q0.size() + q1.size(), 0);
    endtask

    task automatic reset_outputs(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_valid"}, {31'd0, valid}, 0);
        chk({nm, "_gnt"}, {30'd0, gnt1, gnt0}, 0);
        chk({nm, "_sum"}, {16'd0, sum}, 0);
        chk({nm, "_cout_id"}, {30'd0, cout, id}, 0);
    endtask

    logic w;
    int t1, t2;
    logic [15:0] pa[4], pb[4];
    logic pc[4];

    initial begin
        #1 reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 0;
        issue(0, 16'hFFFF, 16'h0001, 0);
        issue(0, 16'h000F, 16'h000F, 1);
        issue(0, 16'h1234, 16'h4321, 0);
        issue(1, 16'h8000, 16'h8000, 1);
        issue(1, 16'h0000, 16'h0000, 0);
        issue(0, 16'hFFFF, 16'hFFFF, 1);
        drain();
        rst = 1;
        @(negedge clk);
        rst = 0;
        a0 = 16'h1111; b0 = 16'h2222; cin0 = 0;
        a1 = 16'hABCD; b1 = 16'h1111; cin1 = 1;
        req0 = 1; req1 = 1;
        q0.push_back(model(a0, b0, cin0, 0));
        q0.push_back(model(a1, b1, cin1, 1));
        wait_gnt(w, t1);
        chk("rr_first", {31'd0, w}, 0);
        req0 = 0;
        wait_gnt(w, t2);
        chk("rr_second", {31'd0, w}, 1);
        chk("gnt_spacing", t2 - t1, 6);
        req1 = 0;
        drain();
        pa = '{16'h0102, 16'hF00F, 16'h7FFF, 16'hC3C3};
        pb = '{16'h0304, 16'h0FF1, 16'h0001, 16'h3C3C};
        pc = '{1'b1, 1'b0, 1'b0, 1'b1};
        a0 = pa[0]; b0 = pb[0]; cin0 = pc[0];
        a1 = pa[1]; b1 = pb[1]; cin1 = pc[1];
        for (int k = 0; k < 4; k++) q0.push_back(model(pa[k], pb[k], pc[k], k[0]));
        req0 = 1; req1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(w, t1);
            chk("rr_seq", {31'd0, w}, {31'd0, k[0]});
            if (k == 0) begin a0 = pa[2]; b0 = pb[2]; cin0 = pc[2]; end
            if (k == 1) begin a1 = pa[3]; b1 = pb[3]; cin1 = pc[3]; end
        end
        req0 = 0; req1 = 0;
        drain();
        a0 = 16'h5555; b0 = 16'h5555; cin0 = 1; req0 = 1;
        wait_gnt(w, t1);
        req0 = 0;
        @(negedge clk);
        rst = 1;
        #1 reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        issue(1, 16'h0F0F, 16'hF0F1, 0);
        for (int k = 0; k < 8; k++)
            issue(1'($urandom_range(1)), 16'($urandom), 16'($urandom), 1'($urandom_range(1)));
        for (int k = 0; k < 8; k++)
            issue1(1'($urandom_range(1)), 4'($urandom), 4'($urandom), 1'($urandom_range(1)));
        issue1(0, 4'hF, 4'h0, 1);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
